// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and constants for the register-file write-back arbiter.
package wb_arbiter_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small in-order buffer for long-latency write-backs, with a per-entry
// valid vector that yields the mask of registers still awaiting a write.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = wb_arbiter_pkg::AW,
  parameter int DW = wb_arbiter_pkg::DW,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  output logic [AW-1:0]       head_addr,
  output logic [DW-1:0]       head_data,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count,
  output logic [NUM_REGS-1:0] pending_mask
);
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    if (pop) valid_d[rd_q] = 1'b0;
    if (push) valid_d[wr_q] = 1'b1;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: the valid vector decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= push_addr;
      data_q[wr_q] <= push_data;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i]) pending_mask[addr_q[i]] = 1'b1;
  end

  assign head_addr = addr_q[rd_q];
  assign head_data = data_q[rd_q];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and buffered long-latency write-backs onto one
// registered register-file write port; pipeline has priority, starvation raises stall_req.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = wb_arbiter_pkg::AW,
  parameter int DW = wb_arbiter_pkg::DW,
  parameter int STARVE_MAX = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p_valid,
  input  logic [AW-1:0]       p_addr,
  input  logic [DW-1:0]       p_data,
  input  logic                l_valid,
  output logic                l_ready,
  input  logic [AW-1:0]       l_addr,
  input  logic [DW-1:0]       l_data,
  output logic                stall_req,
  output logic                reg_write_out,
  output logic [AW-1:0]       write_addr_out,
  output logic [DW-1:0]       write_data_out,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CW-1:0]       fifo_count
);
  logic          p_eff, push, pop, full, empty, inc, hit;
  logic [AW-1:0] head_addr, addr_q, addr_d;
  logic [DW-1:0] head_data, data_q, data_d;
  logic          we_q, we_d, stall_q, stall_d;
  logic [SW-1:0] starve_q, starve_d;

  // Writes to the hard-wired zero register are dropped at the door.
  assign p_eff = p_valid && p_addr != AW'(REG_ZERO);
  assign l_ready = !full;
  assign push = l_valid && l_ready && l_addr != AW'(REG_ZERO);
  assign pop = !p_eff && !empty;
  assign inc = p_eff && !empty;
  assign hit = inc && starve_q == SW'(STARVE_MAX - 1);

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .push_addr    (l_addr),
    .push_data    (l_data),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .full         (full),
    .empty        (empty),
    .count        (fifo_count),
    .pending_mask (pending_mask)
  );

  always_comb begin
    we_d = p_eff || pop;
    addr_d = p_eff ? p_addr : pop ? head_addr : addr_q;
    data_d = p_eff ? p_data : pop ? head_data : data_q;
    starve_d = (inc && !hit) ? starve_q + 1'b1 : '0;
    stall_d = hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      starve_q <= starve_d;
      stall_q <= stall_d;
    end
  end

  assign reg_write_out = we_q;
  assign write_addr_out = addr_q;
  assign write_data_out = data_q;
  assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of the write-back arbiter with hand-computed expectations.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid, l_valid, l_ready, stall_req, reg_write_out;
  logic [4:0]  p_addr, l_addr, write_addr_out;
  logic [31:0] p_data, l_data, write_data_out, pending_mask;
  logic [2:0]  fifo_count;
  int          vecs = 0;
  int          errs = 0;

  wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .p_valid        (p_valid),
    .p_addr         (p_addr),
    .p_data         (p_data),
    .l_valid        (l_valid),
    .l_ready        (l_ready),
    .l_addr         (l_addr),
    .l_data         (l_data),
    .stall_req      (stall_req),
    .reg_write_out  (reg_write_out),
    .write_addr_out (write_addr_out),
    .write_data_out (write_data_out),
    .pending_mask   (pending_mask),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(reg_write_out), 32'(we));
    chk({tag, "_addr"}, 32'(write_addr_out), 32'(a));
    chk({tag, "_data"}, write_data_out, d);
  endtask

  task automatic st(input string tag, input logic [2:0] cnt, input logic [31:0] mask, input logic rdy);
    chk({tag, "_count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, "_mask"}, pending_mask, mask);
    chk({tag, "_ready"}, 32'(l_ready), 32'(rdy));
  endtask

  task automatic idle();
    p_valid = 0; p_addr = 0; p_data = 0;
    l_valid = 0; l_addr = 0; l_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    p_valid = 1; p_addr = a; p_data = d;
  endtask

  task automatic lreq(input logic [4:0] a, input logic [31:0] d);
    l_valid = 1; l_addr = a; l_data = d;
  endtask

  // Upstream must never present a pipeline write while stall_req is high.
  always @(negedge clk) begin
    if (reset === 1'b1 && stall_req === 1'b1) begin
      vecs++;
      assert (p_valid === 1'b0) else begin
        errs++;
        $error("FAIL stall_protocol observed p_valid=%0b expected=0", p_valid);
      end
    end
  end

  initial begin
    idle();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    outs("rst", 0, 0, 0);
    chk("rst_stall", 32'(stall_req), 0);
    st("rst", 0, 0, 1);
    @(negedge clk) reset = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      outs("idle", 0, 0, 0);
      chk("idle_stall", 32'(stall_req), 0);
      st("idle", 0, 0, 1);
    end

    pipe(7, 32'hDEADBEEF);
    step();
    outs("pipe", 1, 7, 32'hDEADBEEF);
    idle();
    step();
    outs("pipe_after", 0, 7, 32'hDEADBEEF);
    pipe(0, 32'h12345678);
    step();
    outs("pipe_zero", 0, 7, 32'hDEADBEEF);

    idle();
    lreq(3, 32'h11);
    step();
    outs("drain0", 0, 7, 32'hDEADBEEF);
    st("drain0", 1, 32'h8, 1);
    lreq(4, 32'h22);
    step();
    outs("drain1", 1, 3, 32'h11);
    st("drain1", 1, 32'h10, 1);
    lreq(3, 32'h33);
    step();
    outs("drain2", 1, 4, 32'h22);
    st("drain2", 1, 32'h8, 1);
    idle();
    step();
    outs("drain3", 1, 3, 32'h33);
    st("drain3", 0, 0, 1);
    step();
    chk("drain_end_we", 32'(reg_write_out), 0);

    pipe(1, 32'hA1); lreq(10, 32'h100);
    step();
    pipe(1, 32'hA2); lreq(11, 32'h101);
    step();
    pipe(1, 32'hA3); lreq(10, 32'h102);
    step();
    pipe(1, 32'hA4); lreq(12, 32'h103);
    step();
    outs("full", 1, 1, 32'hA4);
    st("full", 4, 32'h1C00, 0);
    pipe(1, 32'hA5); lreq(13, 32'h104);
    step();
    outs("held", 1, 1, 32'hA5);
    st("held", 4, 32'h1C00, 0);
    p_valid = 0;
    step();
    outs("pop0", 1, 10, 32'h100);
    st("pop0", 3, 32'h1C00, 1);
    step();
    outs("pop1", 1, 11, 32'h101);
    st("pop1", 3, 32'h3400, 1);
    idle();
    step();
    outs("pop2", 1, 10, 32'h102);
    st("pop2", 2, 32'h3000, 1);
    step();
    outs("pop3", 1, 12, 32'h103);
    step();
    outs("pop4", 1, 13, 32'h104);
    st("pop4", 0, 0, 1);

    pipe(5, 32'h55); lreq(9, 32'h99);
    step();
    l_valid = 0;
    st("starve_load", 1, 32'h200, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("starve_wait", 32'(stall_req), 0);
      outs("starve_pipe", 1, 5, 32'h55);
    end
    step();
    chk("starve_hit", 32'(stall_req), 1);
    p_valid = 0;
    step();
    chk("starve_clear", 32'(stall_req), 0);
    outs("starve_win", 1, 9, 32'h99);
    st("starve_win", 0, 0, 1);

    idle();
    lreq(0, 32'hBAD);
    chk("zero_ready", 32'(l_ready), 1);
    step();
    l_valid = 0;
    st("zero", 0, 0, 1);
    outs("zero", 0, 9, 32'h99);

    pipe(1, 32'hC1); lreq(20, 32'hA);
    step();
    pipe(1, 32'hC2); lreq(21, 32'hB);
    step();
    st("pre_rst", 2, 32'h300000, 1);
    outs("pre_rst", 1, 1, 32'hC2);
    idle();
    #2 reset = 0;
    #1;
    outs("mid_rst", 0, 0, 0);
    st("mid_rst", 0, 0, 1);
    chk("mid_rst_stall", 32'(stall_req), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      outs("post_rst", 0, 0, 0);
      chk("post_rst_count", 32'(fifo_count), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
